q_updater: RTL and testbench
============================

Q_UPDATER -- requirements
Module: q_updater

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning state index width.
REQ-002 SHALL have parameter ALPHA_SHIFT, default 2, meaning learning rate alpha = 2^-ALPHA_SHIFT.
REQ-003 SHALL have parameter GAMMA_SHIFT, default 3, meaning discount gamma = 1 - 2^-GAMMA_SHIFT.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clear  input  1  synchronous flush of pipeline and counter.
REQ-008 total_iteration  input  12  number of updates in the run.
REQ-009 in_valid  input  1  update request valid.
REQ-010 in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-011 state  input  ADDR_W  current state index s.
REQ-012 act  input  2  action a chosen by action_determiner.
REQ-013 reward  input  32  signed reward r.
REQ-014 q_sa  input  32  signed Q(s,a) read from the Q-table.
REQ-015 q_max_next  input  32  signed max Q(s',·).
REQ-016 wr_en  output  1  single-cycle Q-table write strobe.
REQ-017 wr_addr  output  ADDR_W+2  {state, act}.
REQ-018 wr_data  output  32  signed updated Q(s,a).
REQ-019 iteration  output  12  completed-write count, feeds action_determiner.
REQ-020 done  output  1  high while iteration == total_iteration.

Function
REQ-021 SHALL compute Q' = q_sa + ((r + g - q_sa) >>> ALPHA_SHIFT), where g = q_max_next - (q_max_next >>> GAMMA_SHIFT); all shifts arithmetic (floor).
REQ-022 SHALL be a 3-stage pipeline: S1 computes g and registers the operands and the address; S2 computes td = r + g - q_sa at 34 bits, saturated to 32; S3 computes Q' at 33 bits, saturated to 32.
REQ-023 Saturation SHALL clamp to 0x7FFFFFFF / 0x80000000.
REQ-024 wr_en SHALL be high for exactly one cycle, 3 rising edges after the accepting edge, with wr_addr and wr_data valid in that same cycle; wr_data and wr_addr hold their last values otherwise.
REQ-025 SHALL accept one request per cycle when no hazard exists; there is no output backpressure.
REQ-026 in_ready SHALL be low while any valid S1/S2/S3 entry has an address equal to the incoming {state, act} (RAW interlock, combinational on the inputs).
REQ-027 in_ready SHALL be low when iteration + (number of valid in-flight entries) >= total_iteration.
REQ-028 iteration SHALL increment by 1 on each wr_en and never exceed total_iteration.
REQ-029 done SHALL equal (iteration == total_iteration); total_iteration = 0 therefore gives done = 1 and in_ready = 0 from reset.
REQ-030 A change of total_iteration mid-run SHALL take effect immediately in REQ-027 and REQ-029, and SHALL NOT cancel in-flight entries.
REQ-031 clear SHALL invalidate all stages and zero iteration at the next edge; a request presented with clear is not accepted (in_ready = 0 while clear = 1).

Reset
REQ-032 rst_n low SHALL immediately force wr_en = 0, wr_addr = 0, wr_data = 0, iteration = 0 and all stage-valid bits = 0; in-flight updates are discarded.
REQ-033 The first request SHALL be accepted at the first rising edge with rst_n high.

Verification
REQ-034 state=5, act=2, r=100, q_sa=0, q_max_next=80 -> 3 edges later wr_en=1, wr_addr=22, wr_data=42.
REQ-035 r=-50, q_sa=-20, q_max_next=0 -> wr_data=-28 (td=-30, >>>2 gives -8).
REQ-036 r=0x7FFFFFFF, q_max_next=0x7FFFFFFF, q_sa=0x80000000 -> td saturates to 0x7FFFFFFF; wr_data=0x9FFFFFFF.
REQ-037 Back-to-back requests to the same {state, act} -> in_ready low for 3 cycles; second request accepted the cycle after the first wr_en. Distinct addresses -> one write per cycle.
REQ-038 total_iteration=3, 5 requests held valid -> exactly 3 accepted and 3 writes; iteration=3 and done=1; in_ready then stays low.
REQ-039 rst_n pulsed low with 2 entries in flight -> no wr_en follows, iteration=0, next request is processed normally.

Source files
------------

// File: rtl/q_updater_if.sv
// Request/write-back bundle between the Q-learning controller and q_updater.
// The master side issues update requests; the slave side produces Q-table writes.
interface q_updater_if #(
    parameter int ADDR_W = 8
);
    logic              clear;
    logic [11:0]       total_iteration;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] state;
    logic [1:0]        act;
    logic [31:0]       reward;
    logic [31:0]       q_sa;
    logic [31:0]       q_max_next;
    logic              wr_en;
    logic [ADDR_W+1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [11:0]       iteration;
    logic              done;

    modport master (
        output clear, total_iteration, in_valid, state, act, reward, q_sa, q_max_next,
        input  in_ready, wr_en, wr_addr, wr_data, iteration, done
    );

    modport slave (
        input  clear, total_iteration, in_valid, state, act, reward, q_sa, q_max_next,
        output in_ready, wr_en, wr_addr, wr_data, iteration, done
    );
endinterface

// File: rtl/q_updater.sv
// Pipelined Q-learning update: Q' = Q + alpha*(r + gamma*maxQ' - Q) with shift-based
// alpha/gamma, saturating arithmetic, a read-after-write interlock and an update budget.
module q_updater #(
    parameter int ADDR_W      = 8,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    q_updater_if.slave bus
);
    localparam int AW   = ADDR_W + 2;
    localparam int NSTG = 3;

    function automatic logic [31:0] sat34(input logic [33:0] v);
        if (v[33:31] == 3'b000 || v[33:31] == 3'b111) return v[31:0];
        return v[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    function automatic logic [31:0] sat33(input logic [32:0] v);
        if (v[32] == v[31]) return v[31:0];
        return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    logic [NSTG-1:0]    vld_q;
    logic [AW-1:0]      addr_q [NSTG];
    logic signed [31:0] s1_r_q;
    logic signed [31:0] s1_qsa_q;
    logic signed [31:0] s1_g_q;
    logic signed [31:0] s2_td_q;
    logic signed [31:0] s2_qsa_q;
    logic signed [31:0] s3_qnew_q;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [31:0]        wr_data_q;
    logic [11:0]        iter_q;

    logic [AW-1:0]      in_addr;
    logic [NSTG-1:0]    raw_hit;
    logic [1:0]         in_flight;
    logic [12:0]        committed;
    logic               in_ready;
    logic               accept;
    logic signed [31:0] g_d;
    logic [33:0]        td_full;
    logic [31:0]        td_d;
    logic signed [31:0] td_sh;
    logic [32:0]        q_full;
    logic [31:0]        qnew_d;

    assign in_addr = {bus.state, bus.act};

    // An address still travelling through S1..S3 has not reached the table yet,
    // so a new read of it would be stale.
    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_raw
            assign raw_hit[gi] = vld_q[gi] && (addr_q[gi] == in_addr);
        end
    endgenerate

    assign in_flight = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
    assign committed = {1'b0, iter_q} + {11'b0, in_flight};
    assign in_ready  = !bus.clear && (raw_hit == '0)
                       && (committed < {1'b0, bus.total_iteration});
    assign accept    = bus.in_valid && in_ready;

    assign g_d     = $signed(bus.q_max_next) - ($signed(bus.q_max_next) >>> GAMMA_SHIFT);
    assign td_full = {{2{s1_r_q[31]}}, s1_r_q} + {{2{s1_g_q[31]}}, s1_g_q}
                     - {{2{s1_qsa_q[31]}}, s1_qsa_q};
    assign td_d    = sat34(td_full);
    assign td_sh   = s2_td_q >>> ALPHA_SHIFT;
    assign q_full  = {s2_qsa_q[31], s2_qsa_q} + {td_sh[31], td_sh};
    assign qnew_d  = sat33(q_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            for (int i = 0; i < NSTG; i++) addr_q[i] <= '0;
            s1_r_q    <= '0;
            s1_qsa_q  <= '0;
            s1_g_q    <= '0;
            s2_td_q   <= '0;
            s2_qsa_q  <= '0;
            s3_qnew_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            iter_q    <= '0;
        end else begin
            vld_q   <= bus.clear ? '0 : {vld_q[NSTG-2:0], accept};
            wr_en_q <= vld_q[NSTG-1] && !bus.clear;

            if (accept) begin
                addr_q[0] <= in_addr;
                s1_r_q    <= $signed(bus.reward);
                s1_qsa_q  <= $signed(bus.q_sa);
                s1_g_q    <= g_d;
            end
            for (int i = 1; i < NSTG; i++) addr_q[i] <= addr_q[i-1];
            s2_td_q   <= td_d;
            s2_qsa_q  <= s1_qsa_q;
            s3_qnew_q <= qnew_d;

            if (vld_q[NSTG-1] && !bus.clear) begin
                wr_addr_q <= addr_q[NSTG-1];
                wr_data_q <= s3_qnew_q;
            end

            // Counted on the same edge the write appears, so committed never undercounts.
            if (bus.clear)
                iter_q <= '0;
            else if (vld_q[NSTG-1] && (iter_q < bus.total_iteration))
                iter_q <= iter_q + 12'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.iteration = iter_q;
    assign bus.done      = (iter_q == bus.total_iteration);
endmodule

// File: tb/tb_q_updater.sv
// Bench for q_updater: directed vector table, hand-written interlock/budget/clear/reset
// sequences, and random traffic checked against an arithmetic reference and scoreboard.
`timescale 1ns/1ps
module tb_q_updater;
    localparam int ADDR_W = 8;
    localparam int ASH    = 2;
    localparam int GSH    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q_updater_if #(.ADDR_W(ADDR_W)) bus ();

    q_updater #(.ADDR_W(ADDR_W), .ALPHA_SHIFT(ASH), .GAMMA_SHIFT(GSH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];
    int   exp_iter = 0;

    typedef struct {
        logic [7:0]  st;
        logic [1:0]  ac;
        logic [31:0] r;
        logic [31:0] q;
        logic [31:0] m;
        logic [9:0]  ea;
        logic [31:0] ed;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint fdiv(input longint x, input longint d);
        longint qt;
        qt = x / d;
        if ((x % d) != 0 && x < 0) qt -= 1;
        return qt;
    endfunction

    function automatic longint clamp32(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic logic [31:0] ref_q(input logic [31:0] r, input logic [31:0] q,
                                         input logic [31:0] m);
        longint rs, qs, ms, g, td, qn;
        rs = longint'($signed(r));
        qs = longint'($signed(q));
        ms = longint'($signed(m));
        g  = ms - fdiv(ms, longint'(1) << GSH);
        td = clamp32(rs + g - qs);
        qn = clamp32(qs + fdiv(td, longint'(1) << ASH));
        return qn[31:0];
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 2000)) - 32'd1000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard of expected writes plus a model of ready/iteration/done.
    initial begin
        exp_t h;
        bit   hz;
        bit   rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_iter = 0;
                chk("rst_wr_en", bus.wr_en, 0);
                chk("rst_iteration", bus.iteration, 0);
            end else begin
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    h = sb.pop_front();
                    if (exp_iter < int'(bus.total_iteration)) exp_iter++;
                    chk("wr_en", bus.wr_en, 1);
                    chk("wr_addr", bus.wr_addr, h.addr);
                    chk("wr_data", bus.wr_data, h.data);
                    $display("WR cyc=%0d addr=%0d data=0x%08h exp=0x%08h", cyc,
                             bus.wr_addr, bus.wr_data, h.data);
                end else begin
                    chk("wr_en_idle", bus.wr_en, 0);
                end
                chk("iteration", bus.iteration, exp_iter);
                chk("done", bus.done, exp_iter == int'(bus.total_iteration));
                hz = 1'b0;
                foreach (sb[i]) if (sb[i].addr == int'({bus.state, bus.act})) hz = 1'b1;
                rdy = !bus.clear && !hz && ((exp_iter + sb.size()) < int'(bus.total_iteration));
                chk("in_ready", bus.in_ready, rdy);
                if (bus.clear) begin
                    sb.delete();
                    exp_iter = 0;
                end else if (bus.in_valid && bus.in_ready) begin
                    sb.push_back('{addr: int'({bus.state, bus.act}),
                                   data: ref_q(bus.reward, bus.q_sa, bus.q_max_next),
                                   due:  cyc + 4});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] s, input logic [1:0] a, input logic [31:0] r,
                        input logic [31:0] q, input logic [31:0] m);
        bit ok;
        ok = 1'b0;
        bus.state = s; bus.act = a; bus.reward = r; bus.q_sa = q; bus.q_max_next = m;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("accepted", ok, 1);
    endtask

    task automatic run_vec(input int i);
        send(vt[i].st, vt[i].ac, vt[i].r, vt[i].q, vt[i].m);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_wr_en_early", i), bus.wr_en, 0);
        @(negedge clk);
        chk($sformatf("vec%0d_wr_en", i), bus.wr_en, 1);
        chk($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vt[i].ea);
        chk($sformatf("vec%0d_wr_data", i), bus.wr_data, vt[i].ed);
        @(posedge clk); #1;
    endtask

    initial begin
        int nacc, idx, nwr, first, last;
        vt[0] = '{8'd5,   2'd2, 32'd100,       32'd0,         32'd80,        10'd22,   32'd42};
        vt[1] = '{8'd7,   2'd1, 32'hFFFF_FFCE, 32'hFFFF_FFEC, 32'd0,         10'd29,   32'hFFFF_FFE4};
        vt[2] = '{8'd9,   2'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 10'd39,   32'h9FFF_FFFF};
        vt[3] = '{8'd255, 2'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 10'd1023, 32'h5FFF_FFFF};
        vt[4] = '{8'd1,   2'd1, 32'hFFFF_FFFF, 32'd0,         32'd0,         10'd5,    32'hFFFF_FFFF};
        vt[5] = '{8'd3,   2'd0, 32'd0,         32'd3,         32'hFFFF_FFF7, 10'd12,   32'd0};

        bus.clear = 1'b0; bus.total_iteration = 12'd4095; bus.in_valid = 1'b0;
        bus.state = '0; bus.act = '0; bus.reward = '0; bus.q_sa = '0; bus.q_max_next = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors; the first is offered on the first edge out of reset.
        for (int i = 0; i < 6; i++) run_vec(i);

        // Same address back-to-back: held off until the first write is on the bus.
        send(8'd10, 2'd0, 32'd1000, 32'd0, 32'd0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw_ready_low", bus.in_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("raw_ready_at_write", bus.in_ready, 1);
        chk("raw_first_write", bus.wr_en, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Distinct addresses stream at one per cycle.
        for (int k = 0; k < 4; k++) begin
            bus.state = 8'(20 + k); bus.act = 2'd1; bus.reward = rnd32();
            bus.q_sa = rnd32(); bus.q_max_next = rnd32(); bus.in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", bus.in_ready, 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        nwr = 0; first = -1; last = -1;
        repeat (6) begin
            @(negedge clk);
            if (bus.wr_en) begin
                nwr++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("stream_writes", nwr, 4);
        chk("stream_span", last - first, 3);

        // Budget of 3 with requests held valid.
        @(posedge clk); #1;
        bus.total_iteration = 12'd3; bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        nacc = 0; idx = 0; nwr = 0;
        for (int k = 0; k < 12; k++) begin
            bus.state = 8'(40 + idx); bus.act = 2'd0; bus.reward = rnd32();
            bus.q_sa = rnd32(); bus.q_max_next = rnd32(); bus.in_valid = 1'b1;
            @(negedge clk);
            if (bus.wr_en) nwr++;
            if (bus.in_ready) begin
                nacc++;
                if (idx < 4) idx++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("budget_accepts", nacc, 3);
        chk("budget_writes", nwr, 3);
        chk("budget_iteration", bus.iteration, 3);
        chk("budget_done", bus.done, 1);
        chk("budget_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Clear with two entries in flight discards them.
        bus.total_iteration = 12'd4095; bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        bus.state = 8'd50; bus.act = 2'd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.state = 8'd51;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        nwr = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wr_en) nwr++;
        end
        chk("clear_no_write", nwr, 0);
        chk("clear_iteration", bus.iteration, 0);
        @(posedge clk); #1;

        // Reset with two entries in flight.
        run_vec(0);
        bus.state = 8'd60; bus.act = 2'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.state = 8'd61;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstpulse_wr_en", bus.wr_en, 0);
        chk("rstpulse_iteration", bus.iteration, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nwr = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wr_en) nwr++;
        end
        chk("rstpulse_no_write", nwr, 0);
        @(posedge clk); #1;
        run_vec(1);

        // Random traffic over a small address set to provoke interlocks.
        for (int k = 0; k < 400; k++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.state      = 8'($urandom_range(0, 3));
            bus.act        = 2'($urandom_range(0, 3));
            bus.reward     = rnd32();
            bus.q_sa       = rnd32();
            bus.q_max_next = rnd32();
            bus.clear      = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.clear = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
